// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
//   MULT/MULTU use shift-add and DIV/DIVU use restoring division. Each op
//   retires one bit per cycle over WIDTH RUN cycles. HI/LO hold the last
//   result and can also be written directly (MTHI/MTLO).
//
//   Build option: define MULTDIV_SIGNED_EN to enable signed MULT/DIV, which
//   are selected by op[0]. When it is undefined, op[0] is ignored and every
//   op is unsigned.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   start  in   begin an operation (ignored while busy)
//   op     in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      in   multiplicand / dividend (rs)
//   b      in   multiplier / divisor (rt)
//   hi_we  in   MTHI strobe (ignored while busy)
//   lo_we  in   MTLO strobe (ignored while busy)
//   wd     in   MTHI/MTLO data
//   busy   out  operation in progress
//   done   out  one-cycle pulse, result valid in hi/lo
//   div0   out  pulses with done when a divide had b == 0
//   hi     out  HI register (product upper half / remainder)
//   lo     out  LO register (product lower half / quotient)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, one bit per cycle, count = 0..WIDTH-1
// DONE  | result just written to hi/lo; start accepted here as in IDLE

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             zero_div;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] opnd;     // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_hi;   // partial product upper half / remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier shifting out / dividend->quotient
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef MULTDIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_res;   // product or quotient must be negated
  logic neg_rem;   // remainder follows the dividend sign

  // Magnitudes of the most-negative value still fit as unsigned WIDTH bits.
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_mag = a;
  assign b_mag = b;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (count == LAST) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- one iteration ----------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   div_sh;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Remainder < divisor, so after a successful trial subtract the
    // difference always fits back in WIDTH bits.
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_ok   = (div_sh >= {1'b0, opnd});
    div_hi_n = div_ok ? (div_sh[WIDTH-1:0] - opnd) : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo[WIDTH-2:0], div_ok};

    iter_hi  = is_div ? div_hi_n : mul_hi_n;
    iter_lo  = is_div ? div_lo_n : mul_lo_n;
  end

  // ---------------- completion value ----------------
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    res_hi = iter_hi;
    res_lo = iter_lo;
    if (zero_div) begin
      res_hi = a_raw;
      res_lo = {WIDTH{1'b1}};
    end
`ifdef MULTDIV_SIGNED_EN
    else if (!is_div) begin
      if (neg_res) {res_hi, res_lo} = ~{iter_hi, iter_lo} + (2*WIDTH)'(1);
    end else begin
      if (neg_res) res_lo = ~iter_lo + WIDTH'(1);
      if (neg_rem) res_hi = ~iter_hi + WIDTH'(1);
    end
`endif
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      is_div   <= 1'b0;
      zero_div <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
`ifdef MULTDIV_SIGNED_EN
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else if (state != RUN) begin
      if (hi_we) hi_r <= wd;
      if (lo_we) lo_r <= wd;
      if (start) begin
        count    <= '0;
        is_div   <= op[1];
        zero_div <= op[1] & (b == '0);
        a_raw    <= a;
        acc_hi   <= '0;
        if (op[1]) begin
          opnd   <= b_mag;
          acc_lo <= a_mag;
        end else begin
          opnd   <= a_mag;
          acc_lo <= b_mag;
        end
`ifdef MULTDIV_SIGNED_EN
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
`endif
      end
    end else begin
      acc_hi <= iter_hi;
      acc_lo <= iter_lo;
      count  <= count + CW'(1);
      if (count == LAST) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign div0 = (state == DONE) & zero_div;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
